// File: rtl/sata_fis_crc_inserter.sv
// SATA FIS CRC inserter: passes FIS dwords through with zero latency and appends
// a CRC-32 dword, flagged with o_eop, after the last dword of each frame.
module sata_fis_crc_inserter #(
    parameter logic [31:0] CRC_INIT = 32'h52325032
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] i_dat,
    input  logic        i_val,
    input  logic        i_eop,
    output logic        i_rdy,
    output logic [31:0] o_dat,
    output logic        o_val,
    output logic        o_eop,
    input  logic        o_rdy
);

    localparam logic [31:0] CRC_POLY = 32'h04C11DB7;

    typedef enum logic {
        ST_DATA,
        ST_CRC
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] crc_q, crc_d;
    logic        in_xfer;

    // One dword folded into the CRC, bit 31 first, no reflection.
    function automatic logic [31:0] crc_next(input logic [31:0] crc, input logic [31:0] dat);
        logic [31:0] c;
        logic        fb;
        c = crc;
        for (int i = 31; i >= 0; i--) begin
            fb = c[31] ^ dat[i];
            c  = {c[30:0], 1'b0};
            if (fb) c = c ^ CRC_POLY;
        end
        return c;
    endfunction

    always_comb begin
        // NOTE: every output and next-state signal gets a default first so no latch is inferred.
        state_d = state_q;
        crc_d   = crc_q;
        o_dat   = i_dat;
        o_val   = i_val;
        o_eop   = 1'b0;
        i_rdy   = o_rdy;
        in_xfer = 1'b0;
        case (state_q)
            ST_DATA: begin
                in_xfer = i_val & o_rdy;
                if (in_xfer) begin
                    crc_d = crc_next(crc_q, i_dat);
                    if (i_eop) state_d = ST_CRC;
                end
            end
            ST_CRC: begin
                o_dat = crc_q;
                o_val = 1'b1;
                o_eop = 1'b1;
                i_rdy = 1'b0;
                if (o_rdy) begin
                    state_d = ST_DATA;
                    crc_d   = CRC_INIT;
                end
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_DATA;
            crc_q   <= CRC_INIT;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
        end
    end

endmodule
